// File: rtl/mod_pkg.sv
// Shared definitions for the multimode QAM mapper: mode encodings,
// bits-per-symbol lookup and the Gray-to-binary helper used per axis.
package mod_pkg;

  localparam int unsigned MOD_W = 3;

  localparam logic [MOD_W-1:0] MOD_BPSK   = 3'd0;
  localparam logic [MOD_W-1:0] MOD_QPSK   = 3'd1;
  localparam logic [MOD_W-1:0] MOD_16QAM  = 3'd2;
  localparam logic [MOD_W-1:0] MOD_64QAM  = 3'd3;
  localparam logic [MOD_W-1:0] MOD_256QAM = 3'd4;

  // Bits per symbol; 0 marks a reserved mode.
  function automatic logic [3:0] bits_per_sym(input logic [MOD_W-1:0] mode);
    case (mode)
      MOD_BPSK:   return 4'd1;
      MOD_QPSK:   return 4'd2;
      MOD_16QAM:  return 4'd4;
      MOD_64QAM:  return 4'd6;
      MOD_256QAM: return 4'd8;
      default:    return 4'd0;
    endcase
  endfunction

  // Gray-to-binary over the low k bits of g; bits at or above k are ignored.
  function automatic logic [3:0] gray2bin(input logic [3:0] g, input logic [2:0] k);
    logic [3:0]  b;
    logic        acc;
    int unsigned idx;
    b   = '0;
    acc = 1'b0;
    for (int unsigned j = 0; j < 4; j++) begin
      idx = 3 - j;
      if (idx < 32'(k)) begin
        acc         = acc ^ g[idx[1:0]];
        b[idx[1:0]] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/mod_sym_fifo.sv
// Synchronous first-word-fall-through FIFO with drop-on-full.
// A write while full is accepted only when a pop happens in the same cycle.
import mod_pkg::*;

module mod_sym_fifo #(
  parameter int DATA_W = 28,
  parameter int DEPTH  = 8
) (
  input  logic                       r_clk,
  input  logic                       r_rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW:0]       cnt;
  logic              do_rd;
  logic              do_wr;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign fill    = cnt;
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign ovf     = wr_en & full & ~do_rd;
  assign rd_data = empty ? '0 : mem[rp];

  // Storage array; contents are masked while empty so no reset is needed.
  always_ff @(posedge r_clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge r_clk or posedge r_rst_n) begin
    if (r_rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/multimode_qam_mapper.sv
// Serial-bit collector, Gray-coded BPSK..256QAM mapper and symbol FIFO
// with valid/ready output and saturating overflow/drop counters.
import mod_pkg::*;

module multimode_qam_mapper #(
  parameter int IQ_W       = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          r_clk,
  input  logic                          r_rst_n,
  input  logic                          i_en,
  input  logic                          i_data_vld,
  input  logic                          i_data,
  input  logic [2:0]                    i_mod,
  output logic                          o_sym_vld,
  input  logic                          i_sym_rdy,
  output logic [IQ_W-1:0]               o_i,
  output logic [IQ_W-1:0]               o_q,
  output logic [2:0]                    o_sym_mod,
  output logic                          o_sym_first,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill,
  output logic                          o_ovf,
  output logic                          o_drop,
  output logic [CNT_W-1:0]              o_ovf_cnt,
  output logic [CNT_W-1:0]              o_drop_cnt
);

  localparam int ENT_W = 2*IQ_W + 4;

  // Collector state
  logic             en_d;
  logic [2:0]       mode_q;
  logic             first_pend;
  logic [3:0]       bit_cnt;
  logic [6:0]       shreg;

  // Stage 1: assembled word
  logic             s1_vld;
  logic [7:0]       s1_word;
  logic [2:0]       s1_mod;
  logic             s1_first;

  // Collector combinational terms
  logic             start;
  logic             fall;
  logic [2:0]       cur_mode;
  logic [3:0]       cur_b;
  logic             cur_resv;
  logic             take;
  logic [7:0]       sh_nxt;
  logic [3:0]       cnt_nxt;
  logic             sym_done;
  logic             drop_ev;

  // Mapper terms
  logic [2:0]       map_k;
  logic [3:0]       i_bits;
  logic [3:0]       lvl_i;
  logic [3:0]       lvl_q;
  int               span;
  int               scale;
  int               amp_i;
  int               amp_q;

  // FIFO interface
  logic [ENT_W-1:0] wr_data;
  logic [ENT_W-1:0] rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_ovf;
  logic             pop;

  // The latching cycle uses i_mod directly so a bit arriving with the frame edge is mapped correctly.
  always_comb begin
    start    = i_en & ~en_d;
    fall     = ~i_en & en_d;
    cur_mode = start ? i_mod : mode_q;
    cur_b    = bits_per_sym(cur_mode);
    cur_resv = (cur_b == '0);
    take     = i_en & i_data_vld & ~cur_resv;
    sh_nxt   = {shreg, i_data};
    cnt_nxt  = bit_cnt + 4'd1;
    sym_done = take & (cnt_nxt == cur_b);
    drop_ev  = (fall & (bit_cnt != '0)) | (start & cur_resv);
  end

  // Frame tracking, bit collection and stage-1 register.
  always_ff @(posedge r_clk or posedge r_rst_n) begin
    if (r_rst_n) begin
      en_d       <= 1'b0;
      mode_q     <= '0;
      first_pend <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      s1_vld     <= 1'b0;
      s1_word    <= '0;
      s1_mod     <= '0;
      s1_first   <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      en_d   <= i_en;
      o_drop <= drop_ev;
      s1_vld <= sym_done;
      if (start) mode_q <= i_mod;
      if (sym_done)   first_pend <= 1'b0;
      else if (start) first_pend <= 1'b1;
      if (!i_en)     bit_cnt <= '0;
      else if (take) bit_cnt <= sym_done ? 4'd0 : cnt_nxt;
      if (take) shreg <= sh_nxt[6:0];
      if (sym_done) begin
        s1_word  <= sh_nxt;
        s1_mod   <= cur_mode;
        s1_first <= start | first_pend;
      end
    end
  end

  // Gray mapping: I from the upper k bits, Q from the lower k; BPSK drives I only.
  always_comb begin
    map_k  = (s1_mod == MOD_BPSK) ? 3'd1 : 3'(bits_per_sym(s1_mod) >> 1);
    i_bits = (s1_mod == MOD_BPSK) ? s1_word[3:0] : 4'(s1_word >> map_k);
    lvl_i  = gray2bin(i_bits, map_k);
    lvl_q  = gray2bin(s1_word[3:0], map_k);
    span   = (1 << map_k) - 1;
    scale  = 1 << (IQ_W - 1 - int'(map_k));
    amp_i  = (2 * int'(lvl_i) - span) * scale;
    amp_q  = (s1_mod == MOD_BPSK) ? 0 : (2 * int'(lvl_q) - span) * scale;
  end

  assign wr_data = {s1_first, s1_mod, IQ_W'(amp_q), IQ_W'(amp_i)};
  assign pop     = ~fifo_empty & i_sym_rdy;

  mod_sym_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .r_clk   (r_clk),
    .r_rst_n (r_rst_n),
    .wr_en   (s1_vld),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .fill    (o_fill),
    .ovf     (fifo_ovf)
  );

  assign o_sym_vld = ~fifo_empty;
  assign {o_sym_first, o_sym_mod, o_q, o_i} = rd_data;

  // Overflow pulse and saturating event counters.
  always_ff @(posedge r_clk or posedge r_rst_n) begin
    if (r_rst_n) begin
      o_ovf      <= 1'b0;
      o_ovf_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      o_ovf <= fifo_ovf;
      if (fifo_ovf && o_ovf_cnt != '1) o_ovf_cnt  <= o_ovf_cnt + 1'b1;
      if (drop_ev && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multimode_qam_mapper.sv
// Directed self-checking bench for multimode_qam_mapper (IQ_W=12, depth 8).
module tb_multimode_qam_mapper;

  localparam int IQ_W       = 12;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 16;

  logic                        r_clk = 1'b0;
  logic                        r_rst_n = 1'b1;
  logic                        i_en = 1'b0;
  logic                        i_data_vld = 1'b0;
  logic                        i_data = 1'b0;
  logic [2:0]                  i_mod = 3'd0;
  logic                        i_sym_rdy = 1'b0;
  logic                        o_sym_vld;
  logic [IQ_W-1:0]             o_i;
  logic [IQ_W-1:0]             o_q;
  logic [2:0]                  o_sym_mod;
  logic                        o_sym_first;
  logic [$clog2(FIFO_DEPTH):0] o_fill;
  logic                        o_ovf;
  logic                        o_drop;
  logic [CNT_W-1:0]            o_ovf_cnt;
  logic [CNT_W-1:0]            o_drop_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int ovf_seen = 0;
  int drop_seen = 0;

  always #5 r_clk = ~r_clk;

  multimode_qam_mapper #(
    .IQ_W       (IQ_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .r_clk       (r_clk),
    .r_rst_n     (r_rst_n),
    .i_en        (i_en),
    .i_data_vld  (i_data_vld),
    .i_data      (i_data),
    .i_mod       (i_mod),
    .o_sym_vld   (o_sym_vld),
    .i_sym_rdy   (i_sym_rdy),
    .o_i         (o_i),
    .o_q         (o_q),
    .o_sym_mod   (o_sym_mod),
    .o_sym_first (o_sym_first),
    .o_fill      (o_fill),
    .o_ovf       (o_ovf),
    .o_drop      (o_drop),
    .o_ovf_cnt   (o_ovf_cnt),
    .o_drop_cnt  (o_drop_cnt)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge r_clk) begin
    if (o_ovf === 1'b1)  ovf_seen++;
    if (o_drop === 1'b1) drop_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge r_clk);
    #1;
  endtask

  // One frame, bits sent MSB-first from bits[n-1] down to bits[0], then one idle cycle.
  task automatic send_frame(input logic [2:0] mode, input logic [15:0] bits, input int n);
    i_en  = 1'b1;
    i_mod = mode;
    for (int j = n - 1; j >= 0; j--) begin
      i_data_vld = 1'b1;
      i_data     = bits[j];
      cyc();
    end
    i_en       = 1'b0;
    i_data_vld = 1'b0;
    i_data     = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    r_rst_n = 1'b1;
    repeat (3) cyc();
    n_chk++; if (o_sym_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b expected 0", o_sym_vld); end
    n_chk++; if (o_fill !== '0) begin n_fail++; $display("FAIL rst_fill: got %0d expected 0", o_fill); end
    n_chk++; if ({o_i, o_q, o_sym_mod, o_sym_first} !== '0) begin n_fail++; $display("FAIL rst_data: got i=%0d q=%0d", o_i, o_q); end
    n_chk++; if ({o_ovf, o_drop, o_ovf_cnt, o_drop_cnt} !== '0) begin n_fail++; $display("FAIL rst_events: got ovf_cnt=%0d drop_cnt=%0d", o_ovf_cnt, o_drop_cnt); end
    r_rst_n = 1'b0;
    cyc();
  endtask

  task automatic test_bpsk();
    i_sym_rdy = 1'b0;
    i_en = 1'b1; i_mod = 3'd0; i_data_vld = 1'b1; i_data = 1'b1;
    cyc();
    n_chk++; if (o_sym_vld !== 1'b0) begin n_fail++; $display("FAIL bpsk_lat1: got %b expected 0", o_sym_vld); end
    i_data = 1'b0;
    cyc();
    n_chk++; if (o_sym_vld !== 1'b1) begin n_fail++; $display("FAIL bpsk_lat2: got %b expected 1", o_sym_vld); end
    n_chk++; if ($signed(o_i) !== 1024 || $signed(o_q) !== 0) begin n_fail++; $display("FAIL bpsk_sym0: got (%0d,%0d) expected (1024,0)", $signed(o_i), $signed(o_q)); end
    n_chk++; if (o_sym_first !== 1'b1 || o_sym_mod !== 3'd0) begin n_fail++; $display("FAIL bpsk_tag0: got first=%b mod=%0d expected 1,0", o_sym_first, o_sym_mod); end
    i_en = 1'b0; i_data_vld = 1'b0;
    cyc();
    n_chk++; if (o_fill !== 4'd2) begin n_fail++; $display("FAIL bpsk_fill: got %0d expected 2", o_fill); end
    n_chk++; if ($signed(o_i) !== 1024) begin n_fail++; $display("FAIL bpsk_hold: got %0d expected 1024", $signed(o_i)); end
    i_sym_rdy = 1'b1;
    cyc();
    n_chk++; if ($signed(o_i) !== -1024 || $signed(o_q) !== 0) begin n_fail++; $display("FAIL bpsk_sym1: got (%0d,%0d) expected (-1024,0)", $signed(o_i), $signed(o_q)); end
    n_chk++; if (o_sym_first !== 1'b0) begin n_fail++; $display("FAIL bpsk_first1: got %b expected 0", o_sym_first); end
    cyc();
    n_chk++; if (o_sym_vld !== 1'b0) begin n_fail++; $display("FAIL bpsk_drain: got %b expected 0", o_sym_vld); end
    i_sym_rdy = 1'b0;
  endtask

  task automatic test_qam_modes();
    logic [2:0]  modes [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [15:0] pats  [4] = '{16'b01, 16'b1011, 16'b000000, 16'b10001000};
    int          lens  [4] = '{2, 4, 6, 8};
    int          exp_i [4] = '{-1024, 1536, -1792, 1920};
    int          exp_q [4] = '{1024, 512, -1792, 1920};
    for (int t = 0; t < 4; t++) begin
      send_frame(modes[t], pats[t], lens[t]);
      n_chk++; if (o_sym_vld !== 1'b1 || o_fill !== 4'd1) begin n_fail++; $display("FAIL qam%0d_vld: got vld=%b fill=%0d expected 1,1", t, o_sym_vld, o_fill); end
      n_chk++; if ($signed(o_i) !== exp_i[t] || $signed(o_q) !== exp_q[t]) begin n_fail++; $display("FAIL qam%0d_iq: got (%0d,%0d) expected (%0d,%0d)", t, $signed(o_i), $signed(o_q), exp_i[t], exp_q[t]); end
      n_chk++; if (o_sym_mod !== modes[t] || o_sym_first !== 1'b1) begin n_fail++; $display("FAIL qam%0d_tag: got mod=%0d first=%b expected %0d,1", t, o_sym_mod, o_sym_first, modes[t]); end
      i_sym_rdy = 1'b1;
      cyc();
      i_sym_rdy = 1'b0;
    end
  endtask

  task automatic test_overflow();
    logic [9:0] pat = 10'b1011001011;
    int         exp_i;
    int         base = ovf_seen;
    i_sym_rdy = 1'b0;
    send_frame(3'd0, 16'(pat), 10);
    cyc();
    n_chk++; if (o_fill !== 4'd8) begin n_fail++; $display("FAIL ovf_fill: got %0d expected 8", o_fill); end
    n_chk++; if (ovf_seen - base !== 2) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 2", ovf_seen - base); end
    n_chk++; if (o_ovf_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 2", o_ovf_cnt); end
    for (int s = 0; s < 8; s++) begin
      exp_i = pat[9 - s] ? 1024 : -1024;
      n_chk++; if (o_sym_vld !== 1'b1 || $signed(o_i) !== exp_i || o_sym_first !== (s == 0)) begin n_fail++; $display("FAIL ovf_drain%0d: got vld=%b i=%0d first=%b expected 1,%0d,%b", s, o_sym_vld, $signed(o_i), o_sym_first, exp_i, s == 0); end
      i_sym_rdy = 1'b1;
      cyc();
      i_sym_rdy = 1'b0;
    end
    n_chk++; if (o_sym_vld !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", o_sym_vld); end
  endtask

  task automatic test_partial_drop();
    int base = drop_seen;
    send_frame(3'd2, 16'b101101, 6);
    send_frame(3'd2, 16'b0000, 4);
    cyc();
    n_chk++; if (drop_seen - base !== 1) begin n_fail++; $display("FAIL drop_pulses: got %0d expected 1", drop_seen - base); end
    n_chk++; if (o_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d expected 1", o_drop_cnt); end
    n_chk++; if (o_fill !== 4'd2) begin n_fail++; $display("FAIL drop_fill: got %0d expected 2", o_fill); end
    n_chk++; if ($signed(o_i) !== 1536 || $signed(o_q) !== 512 || o_sym_first !== 1'b1) begin n_fail++; $display("FAIL drop_sym0: got (%0d,%0d) first=%b expected (1536,512) 1", $signed(o_i), $signed(o_q), o_sym_first); end
    i_sym_rdy = 1'b1;
    cyc();
    i_sym_rdy = 1'b0;
    n_chk++; if ($signed(o_i) !== -1536 || $signed(o_q) !== -1536 || o_sym_first !== 1'b1) begin n_fail++; $display("FAIL drop_sym1: got (%0d,%0d) first=%b expected (-1536,-1536) 1", $signed(o_i), $signed(o_q), o_sym_first); end
    i_sym_rdy = 1'b1;
    cyc();
    i_sym_rdy = 1'b0;
  endtask

  task automatic test_reserved();
    int base = drop_seen;
    send_frame(3'd6, 16'b1010, 4);
    cyc();
    cyc();
    n_chk++; if (o_sym_vld !== 1'b0 || o_fill !== '0) begin n_fail++; $display("FAIL resv_out: got vld=%b fill=%0d expected 0,0", o_sym_vld, o_fill); end
    n_chk++; if (drop_seen - base !== 1) begin n_fail++; $display("FAIL resv_pulse: got %0d expected 1", drop_seen - base); end
    n_chk++; if (o_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL resv_cnt: got %0d expected 2", o_drop_cnt); end
  endtask

  task automatic test_midframe_reset();
    int base;
    i_sym_rdy = 1'b0;
    send_frame(3'd0, 16'b110, 3);
    cyc();
    n_chk++; if (o_fill !== 4'd3) begin n_fail++; $display("FAIL mrst_pre: got %0d expected 3", o_fill); end
    i_en = 1'b1; i_mod = 3'd1; i_data_vld = 1'b1; i_data = 1'b1;
    cyc();
    base = drop_seen;
    r_rst_n = 1'b1;
    #1;
    n_chk++; if (o_sym_vld !== 1'b0 || o_fill !== '0) begin n_fail++; $display("FAIL mrst_async: got vld=%b fill=%0d expected 0,0", o_sym_vld, o_fill); end
    i_en = 1'b0; i_data_vld = 1'b0; i_data = 1'b0;
    cyc();
    r_rst_n = 1'b0;
    cyc();
    cyc();
    n_chk++; if (drop_seen !== base || o_drop_cnt !== '0) begin n_fail++; $display("FAIL mrst_nodrop: got pulses=%0d cnt=%0d expected 0,0", drop_seen - base, o_drop_cnt); end
    send_frame(3'd1, 16'b11, 2);
    n_chk++; if ($signed(o_i) !== 1024 || $signed(o_q) !== 1024 || o_sym_mod !== 3'd1 || o_sym_first !== 1'b1) begin n_fail++; $display("FAIL mrst_qpsk: got (%0d,%0d) mod=%0d first=%b expected (1024,1024) 1 1", $signed(o_i), $signed(o_q), o_sym_mod, o_sym_first); end
    n_chk++; if (o_fill !== 4'd1) begin n_fail++; $display("FAIL mrst_fill: got %0d expected 1", o_fill); end
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qam_modes();
    test_overflow();
    test_partial_drop();
    test_reserved();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
